// File: rtl/seq_adder_n_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_adder_n_if : operand/result handshake bundle for seq_adder_n      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface seq_adder_n_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seq_adder_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_adder_n : multi-cycle adder, CHUNK bits per clock, valid/ready IO |
// | Optional macro SEQ_ADDER_SUB_EN enables b inversion when sub=1        |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_adder_n #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_adder_n_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_b_in;
  logic [CHUNK:0]   w_chunk;
  logic             w_ovf;
  logic             w_accept;
  logic             w_last;
  int               w_base;

`ifdef SEQ_ADDER_SUB_EN
  assign w_b_in = bus.sub ? ~bus.b : bus.b;
`else
  logic w_unused_sub;
  assign w_b_in       = bus.b;
  assign w_unused_sub = bus.sub;
`endif

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == C_LAST);
  assign w_base   = int'(r_cnt) * CHUNK;
  assign w_chunk  = {1'b0, r_a[w_base +: CHUNK]} + {1'b0, r_b[w_base +: CHUNK]}
                  + {{CHUNK{1'b0}}, r_carry};
  // Carry into the MSB equals a^b^s at that bit; only used on the top chunk.
  assign w_ovf    = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_chunk[CHUNK-1] ^ w_chunk[CHUNK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)  w_next = RUN;
      RUN:     if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= w_b_in;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum[w_base +: CHUNK] <= w_chunk[CHUNK-1:0];
      r_carry                <= w_chunk[CHUNK];
      r_cnt                  <= r_cnt + CW'(1);
      if (w_last) begin
        r_cout <= w_chunk[CHUNK];
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.s         = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_seq_adder_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_adder_n : random + directed bench, CHUNK=8 and CHUNK=32 DUTs   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_seq_adder_n;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] drv_a = '0;
  logic [31:0] drv_b = '0;
  logic        drv_cin = 1'b0;
  logic        drv_sub = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rst_seen = 1'b0;

  // Per-DUT model: 0 idle, 1 busy, 2 result pending
  int          m_st  [2];
  int          m_due [2];
  logic [31:0] m_s   [2];
  logic        m_c   [2];
  logic        m_o   [2];

  seq_adder_n_if #(.WIDTH(32)) bus0 ();
  seq_adder_n_if #(.WIDTH(32)) bus1 ();

  seq_adder_n #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seq_adder_n #(.WIDTH(32), .CHUNK(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.in_valid  = in_valid;
  assign bus0.out_ready = out_ready;
  assign bus0.a         = drv_a;
  assign bus0.b         = drv_b;
  assign bus0.cin       = drv_cin;
  assign bus0.sub       = drv_sub;
  assign bus1.in_valid  = in_valid;
  assign bus1.out_ready = out_ready;
  assign bus1.a         = drv_a;
  assign bus1.b         = drv_b;
  assign bus1.cin       = drv_cin;
  assign bus1.sub       = drv_sub;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // {ovf, cout, s} from plain arithmetic
  function automatic logic [33:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic sb);
    logic [31:0] yy;
    logic [32:0] sum;
    logic        v;
    yy = y;
`ifdef SEQ_ADDER_SUB_EN
    if (sb) yy = ~y;
`else
    if (sb) yy = y;
`endif
    sum = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
    v   = (x[31] == yy[31]) && (sum[31] != x[31]);
    return {v, sum};
  endfunction

  task automatic step(input int k, input int n, input logic ir, input logic ov,
                      input logic [31:0] s, input logic co, input logic of);
    logic [33:0] r;
    check($sformatf("d%0d in_ready", k), {31'd0, ir}, {31'd0, m_st[k] == 0});
    check($sformatf("d%0d out_valid", k), {31'd0, ov}, {31'd0, m_st[k] == 2});
    if (m_st[k] == 2) begin
      check($sformatf("d%0d s", k), s, m_s[k]);
      check($sformatf("d%0d cout", k), {31'd0, co}, {31'd0, m_c[k]});
      check($sformatf("d%0d ovf", k), {31'd0, of}, {31'd0, m_o[k]});
    end
    if (rst_n) begin
      case (m_st[k])
        0: if (in_valid) begin
          r        = ref_add(drv_a, drv_b, drv_cin, drv_sub);
          m_s[k]   = r[31:0];
          m_c[k]   = r[32];
          m_o[k]   = r[33];
          m_due[k] = cyc + 1 + n;
          m_st[k]  = 1;
        end
        1: if (cyc + 1 == m_due[k]) m_st[k] = 2;
        default: if (out_ready) m_st[k] = 0;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (rst_seen || !rst_n) begin
      m_st[0]  = 0;
      m_st[1]  = 0;
      rst_seen = 1'b0;
    end
    step(0, 4, bus0.in_ready, bus0.out_valid, bus0.s, bus0.cout, bus0.ovf);
    step(1, 1, bus1.in_ready, bus1.out_valid, bus1.s, bus1.cout, bus1.ovf);
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
  endtask

  // Counts negedges after the acceptance edge until each out_valid rises
  task automatic wait_lat(output int l0, output int l1);
    l0 = -1;
    l1 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus0.out_valid && l0 < 0) l0 = k - 1;
      if (bus1.out_valid && l1 < 0) l1 = k - 1;
    end
  endtask

  task automatic check_result(input string nm, input int l0, input int l1,
                              input logic [31:0] es, input logic ec, input logic eo);
    check({nm, " d0 latency"}, 32'(l0), 32'd4);
    check({nm, " d1 latency"}, 32'(l1), 32'd1);
    check({nm, " d0 s"}, bus0.s, es);
    check({nm, " d1 s"}, bus1.s, es);
    check({nm, " d0 cout"}, {31'd0, bus0.cout}, {31'd0, ec});
    check({nm, " d0 ovf"}, {31'd0, bus0.ovf}, {31'd0, eo});
    check({nm, " d1 cout"}, {31'd0, bus1.cout}, {31'd0, ec});
    check({nm, " d1 ovf"}, {31'd0, bus1.ovf}, {31'd0, eo});
  endtask

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tci, input logic tsb,
                        input logic [31:0] es, input logic ec, input logic eo);
    int l0, l1;
    drain();
    in_valid = 1'b1;
    drv_a    = ta;
    drv_b    = tb_;
    drv_cin  = tci;
    drv_sub  = tsb;
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the result must not move.
    in_valid = 1'b0;
    drv_a    = $urandom;
    drv_b    = $urandom;
    drv_cin  = 1'($urandom);
    drv_sub  = 1'($urandom);
    wait_lat(l0, l1);
    check_result(nm, l0, l1, es, ec, eo);
  endtask

  task automatic check_zero(input string nm);
    check({nm, " d0 in_ready"}, {31'd0, bus0.in_ready}, 32'd1);
    check({nm, " d0 out_valid"}, {31'd0, bus0.out_valid}, 32'd0);
    check({nm, " d0 s"}, bus0.s, 32'd0);
    check({nm, " d0 cout/ovf"}, {30'd0, bus0.cout, bus0.ovf}, 32'd0);
    check({nm, " d1 in_ready"}, {31'd0, bus1.in_ready}, 32'd1);
    check({nm, " d1 out_valid"}, {31'd0, bus1.out_valid}, 32'd0);
    check({nm, " d1 s"}, bus1.s, 32'd0);
  endtask

  initial begin
    int l0, l1, pulses;
    logic [31:0] corner [4];
    corner[0] = 32'h0;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    run_op("carry wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("pos ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("chunk32", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
`ifdef SEQ_ADDER_SUB_EN
    run_op("sub 5-7", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
`else
    run_op("sub ignored", 32'd5, 32'd7, 1'b1, 1'b1, 32'h0000_000D, 1'b0, 1'b0);
`endif

    // Hold in DONE while new operands are offered
    run_op("hold first", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      drv_a    = 32'h4000_0000;
      drv_b    = 32'h4000_0000;
      drv_cin  = 1'b0;
      drv_sub  = 1'b0;
    end
    check("hold s", bus0.s, 32'h3333_3333);
    check("hold in_ready", {31'd0, bus0.in_ready}, 32'd0);
    check("hold out_valid", {31'd0, bus0.out_valid}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("release in_ready", {31'd0, bus0.in_ready}, 32'd1);
    check("release out_valid", {31'd0, bus0.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("second accepted", {31'd0, bus0.in_ready}, 32'd0);
    wait_lat(l0, l1);
    check_result("hold second", l0, l1, 32'h8000_0000, 1'b0, 1'b1);

    // Reset during the third RUN cycle
    drain();
    in_valid = 1'b1;
    drv_a    = 32'h0000_FFFF;
    drv_b    = 32'd1;
    drv_cin  = 1'b0;
    drv_sub  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("mid reset");
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid) pulses++;
    end
    check("no pulse after reset", 32'(pulses), 32'd0);
    run_op("after reset", 32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Randomised traffic against the model
    drain();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 7);
      drv_a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      drv_b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      drv_cin   = 1'($urandom);
      drv_sub   = 1'($urandom);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/seq_adder_n.md
SEQ_ADDER_N -- requirements
Module: seq_adder_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, meaning bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, with NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in to bit 0.
REQ-010 The block SHALL have port sub, input, 1 bit: subtract-mode request (see Configuration).
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port s, output, WIDTH bits: sum.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement overflow, equal to carry into the MSB XOR cout.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE with in_valid=1: the block SHALL register a, b (or ~b when subtracting), cin, clear the chunk counter and go to RUN.
REQ-018 In RUN the block SHALL add chunk k, bits [k*CHUNK +: CHUNK], on clock k+1 after acceptance, with registered carry between chunks; each cycle's carry-in is the previous chunk's carry-out, and chunk 0 uses the registered cin.
REQ-019 After the chunk NCHUNK-1 update, the block SHALL enter DONE; out_valid is therefore first high exactly NCHUNK cycles after the acceptance edge.
REQ-020 s, cout and ovf SHALL be stable throughout DONE and are only meaningful while out_valid=1.
REQ-021 DONE with out_ready=1 SHALL return to IDLE on the next edge; DONE with out_ready=0 SHALL hold all outputs indefinitely.
REQ-022 in_valid while not in IDLE SHALL be ignored; no operand is captured, queued or lost silently beyond the handshake, and there is no same-cycle DONE-to-accept.
REQ-023 Operand inputs changing after acceptance SHALL NOT affect the result in progress.
REQ-024 Arithmetic is modulo 2^WIDTH; the carry out of the top chunk SHALL be cout.
REQ-025 CHUNK = WIDTH SHALL be legal, giving a latency of 1 cycle.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, in_ready=1, out_valid=0, s=0, cout=0, ovf=0, and clear the counter and carry register.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result emitted; the first acceptance is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro SEQ_ADDER_SUB_EN defined, sub=1 at acceptance SHALL register ~b in place of b, so the result is a + ~b + cin; cin=1 gives a-b, and cout=1 means no borrow.
REQ-029 Without SEQ_ADDER_SUB_EN, the sub port SHALL exist but be ignored (always add), and no inversion logic is synthesised.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-030 a=0xFFFFFFFF, b=1, cin=0 -> s=0x00000000, cout=1, ovf=0, out_valid high exactly 4 cycles after the acceptance edge.
REQ-031 a=0x7FFFFFFF, b=1, cin=0 -> s=0x80000000, cout=0, ovf=1.
REQ-032 a=5, b=7, sub=1, cin=1 with SEQ_ADDER_SUB_EN -> s=0xFFFFFFFE, cout=0, ovf=0; the same stimulus without the macro -> s=0x0000000D.
REQ-033 Result in DONE with out_ready=0 for 10 cycles, in_valid=1 with new operands throughout -> s unchanged, in_ready=0, the new operands are not accepted; after out_ready=1 -> IDLE, then the new operands are accepted.
REQ-034 rst_n pulsed low during the third RUN cycle -> all outputs 0 and in_ready=1 immediately; no out_valid pulse follows; the next operation completes normally.
REQ-035 WIDTH=32, CHUNK=32, a=0x12345678, b=0x11111111 -> s=0x23456789, out_valid 1 cycle after acceptance.
